// File: rtl/round_robin_arbiter_weighted.sv
// Weighted round-robin arbiter with downstream backpressure and early release.
// A granted requester keeps the resource for up to its weight in accepted beats.
module round_robin_arbiter_weighted #(
  parameter int REQ_NUM  = 8,
  parameter int WEIGHT_W = 4,
  localparam int IDX_W   = $clog2(REQ_NUM)
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [REQ_NUM-1:0]           reqs,
  input  logic [REQ_NUM*WEIGHT_W-1:0]  weights,
  input  logic                         gnt_ready,
  output logic [REQ_NUM-1:0]           grants,
  output logic [IDX_W-1:0]             grant_idx,
  output logic                         grant_valid
);

  typedef enum logic {IDLE, HOLD} state_t;

  state_t                state, state_n;
  logic [IDX_W-1:0]      ptr, ptr_n;
  logic [WEIGHT_W-1:0]   cnt, cnt_n;
  logic [WEIGHT_W-1:0]   quota, quota_n;
  logic [REQ_NUM-1:0]    grants_n;
  logic [IDX_W-1:0]      grant_idx_n;
  logic                  grant_valid_n;

  logic [WEIGHT_W-1:0]   w_arr [REQ_NUM];
  logic [REQ_NUM-1:0]    pick_req;
  logic [IDX_W-1:0]      pick_start;
  logic [IDX_W:0]        pick;
  logic                  take, rel, beat, drop, exhaust;
  logic [IDX_W-1:0]      nxt;

  // Returns {found, index}: scanning from the far end keeps the nearest hit.
  function automatic logic [IDX_W:0] rr_pick(input logic [REQ_NUM-1:0] r,
                                             input logic [IDX_W-1:0]   start);
    logic             found;
    logic [IDX_W-1:0] idx;
    logic [IDX_W-1:0] ki;
    int               k;
    found = 1'b0;
    idx   = '0;
    for (int d = REQ_NUM - 1; d >= 0; d--) begin
      k = int'(start) + d;
      if (k >= REQ_NUM) k = k - REQ_NUM;
      ki = k[IDX_W-1:0];
      if (r[ki]) begin
        found = 1'b1;
        idx   = ki;
      end
    end
    return {found, idx};
  endfunction

  function automatic logic [WEIGHT_W-1:0] eff_w(input logic [WEIGHT_W-1:0] w);
    return (w == '0) ? WEIGHT_W'(1) : w;
  endfunction

  for (genvar i = 0; i < REQ_NUM; i++) begin : g_w
    assign w_arr[i] = weights[i*WEIGHT_W +: WEIGHT_W];
  end

  assign beat    = reqs[grant_idx] & gnt_ready;
  assign drop    = ~reqs[grant_idx];
  assign exhaust = beat && ((cnt + WEIGHT_W'(1)) == quota);
  assign nxt     = (grant_idx == IDX_W'(REQ_NUM - 1)) ? '0 : grant_idx + 1'b1;

  always_comb begin
    state_n       = state;
    ptr_n         = ptr;
    cnt_n         = cnt;
    quota_n       = quota;
    grants_n      = grants;
    grant_idx_n   = grant_idx;
    grant_valid_n = grant_valid;
    pick_req      = reqs;
    pick_start    = ptr;
    take          = 1'b0;
    rel           = 1'b0;

    case (state)
      IDLE: take = 1'b1;
      HOLD: begin
        if (drop) begin
          // The dropping requester is excluded from the immediate hand-over.
          rel        = 1'b1;
          pick_req   = reqs & ~grants;
          pick_start = nxt;
        end else if (exhaust) begin
          rel        = 1'b1;
          pick_start = nxt;
        end else begin
          cnt_n = cnt + {{(WEIGHT_W-1){1'b0}}, beat};
        end
      end
      default: state_n = IDLE;
    endcase

    pick = rr_pick(pick_req, pick_start);

    if (rel) ptr_n = nxt;

    if ((take || rel) && pick[IDX_W]) begin
      state_n                = HOLD;
      grants_n               = '0;
      grants_n[pick[IDX_W-1:0]] = 1'b1;
      grant_idx_n            = pick[IDX_W-1:0];
      grant_valid_n          = 1'b1;
      cnt_n                  = '0;
      quota_n                = eff_w(w_arr[pick[IDX_W-1:0]]);
    end else if (rel) begin
      state_n       = IDLE;
      grants_n      = '0;
      grant_idx_n   = '0;
      grant_valid_n = 1'b0;
      cnt_n         = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      ptr         <= '0;
      cnt         <= '0;
      quota       <= '0;
      grants      <= '0;
      grant_idx   <= '0;
      grant_valid <= 1'b0;
    end else begin
      state       <= state_n;
      ptr         <= ptr_n;
      cnt         <= cnt_n;
      quota       <= quota_n;
      grants      <= grants_n;
      grant_idx   <= grant_idx_n;
      grant_valid <= grant_valid_n;
    end
  end

endmodule

// File: tb/tb_round_robin_arbiter_weighted.sv
// Scoreboard bench for the weighted round-robin arbiter (4 requesters).
// Stimulus pushes the hand-computed grant expected after each edge; the monitor checks it.
module tb_round_robin_arbiter_weighted;

  localparam int N  = 4;
  localparam int WW = 4;

  logic            clk;
  logic            rst_n;
  logic [N-1:0]    reqs;
  logic [N*WW-1:0] weights;
  logic            gnt_ready;
  logic [N-1:0]    grants;
  logic [1:0]      grant_idx;
  logic            grant_valid;

  logic [N-1:0]    exp_q[$];
  int              total = 0;
  int              bad   = 0;

  round_robin_arbiter_weighted #(.REQ_NUM(N), .WEIGHT_W(WW)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .reqs       (reqs),
    .weights    (weights),
    .gnt_ready  (gnt_ready),
    .grants     (grants),
    .grant_idx  (grant_idx),
    .grant_valid(grant_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Apply inputs for the next edge and record the grant expected right after it.
  task automatic step(input logic [N-1:0] r, input logic rdy, input logic [N-1:0] e);
    reqs      = r;
    gnt_ready = rdy;
    @(posedge clk);
    exp_q.push_back(e);
    #1;
  endtask

  // Monitor: pops one expectation per cycle once the DUT has produced it.
  initial begin
    logic [N-1:0] e;
    logic [1:0]   ei;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e  = exp_q.pop_front();
        ei = '0;
        for (int i = 0; i < N; i++) if (e[i]) ei = 2'(i);
        check("grants", 32'(grants), 32'(e));
        check("grant_valid", 32'(grant_valid), 32'(|e));
        if (|e) check("grant_idx", 32'(grant_idx), 32'(ei));
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time budget");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n     = 1'b0;
    reqs      = 4'hF;
    gnt_ready = 1'b1;
    weights   = {4'd1, 4'd1, 4'd1, 4'd1};

    // Reset held with all requesting
    #23;
    check("rst_grants", 32'(grants), 32'h0);
    check("rst_valid", 32'(grant_valid), 32'h0);
    check("rst_idx", 32'(grant_idx), 32'h0);
    #4 rst_n = 1'b1;
    step(4'hF, 1'b1, 4'b0001);

    // Equal weights: one beat each, no bubbles
    step(4'hF, 1'b1, 4'b0010);
    step(4'hF, 1'b1, 4'b0100);
    step(4'hF, 1'b1, 4'b1000);
    step(4'h0, 1'b1, 4'b0000);

    // Weights {w3..w0} = {0,1,2,3}
    weights = {4'd0, 4'd1, 4'd2, 4'd3};
    step(4'hF, 1'b1, 4'b0001);
    step(4'hF, 1'b1, 4'b0001);
    step(4'hF, 1'b1, 4'b0001);
    step(4'hF, 1'b1, 4'b0010);
    step(4'hF, 1'b1, 4'b0010);
    step(4'hF, 1'b1, 4'b0100);
    step(4'hF, 1'b1, 4'b1000);
    step(4'hF, 1'b1, 4'b0001);
    // Weight change mid-grant must not shorten the latched quota of 3
    weights = {4'd1, 4'd1, 4'd1, 4'd1};
    step(4'hF, 1'b1, 4'b0001);
    step(4'hF, 1'b1, 4'b0001);
    step(4'hF, 1'b1, 4'b0010);
    step(4'h0, 1'b1, 4'b0000);

    // Backpressure freezes the beat count
    weights = {4'd1, 4'd1, 4'd2, 4'd2};
    step(4'b0011, 1'b0, 4'b0001);
    step(4'b0011, 1'b0, 4'b0001);
    step(4'b0011, 1'b0, 4'b0001);
    step(4'b0011, 1'b0, 4'b0001);
    step(4'b0011, 1'b1, 4'b0001);
    step(4'b0011, 1'b1, 4'b0010);
    step(4'h0, 1'b1, 4'b0000);

    // Early release on drop, then sole requester re-granted on exhaustion
    weights = {4'd1, 4'd1, 4'd2, 4'd3};
    step(4'b0011, 1'b1, 4'b0001);
    step(4'b0011, 1'b1, 4'b0001);
    step(4'b0010, 1'b1, 4'b0010);
    step(4'b0010, 1'b1, 4'b0010);
    step(4'b0010, 1'b1, 4'b0010);
    step(4'b0010, 1'b1, 4'b0010);
    step(4'b0000, 1'b1, 4'b0000);

    // Reset in the middle of a grant to requester 2
    weights = {4'd1, 4'd2, 4'd2, 4'd2};
    step(4'b0100, 1'b1, 4'b0100);
    step(4'b0100, 1'b1, 4'b0100);
    @(negedge clk);
    #1;
    reqs  = 4'hF;
    rst_n = 1'b0;
    #1;
    check("midrst_grants", 32'(grants), 32'h0);
    check("midrst_valid", 32'(grant_valid), 32'h0);
    check("midrst_idx", 32'(grant_idx), 32'h0);
    #10 rst_n = 1'b1;
    step(4'hF, 1'b1, 4'b0001);
    step(4'hF, 1'b1, 4'b0001);
    step(4'hF, 1'b1, 4'b0010);

    repeat (3) @(negedge clk);
    #1;
    check("scoreboard_drained", 32'(exp_q.size()), 32'h0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
